// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: register map,
// CTRL bit positions, scan FSM encodings and the hex-to-segment table.
package seg_pkg;

  localparam logic [3:0] REG_CTRL = 4'h8;  // word offset 0x20
  localparam logic [3:0] REG_DIV  = 4'h9;  // word offset 0x24

  localparam int CTRL_EN     = 0;
  localparam int CTRL_DECODE = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  // Entry k is the active-high a..g pattern for hex digit k (bit7 unused here).
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to seven-segment pattern, with the decimal point
// passed through on bit 7.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  logic [7:0] hex_pat;

  assign hex_pat = HEX_SEG[nib_i];
  assign seg_o   = {dp_i, hex_pat[6:0]};

endmodule

// File: rtl/seg_scan_ctrl.sv
// AHB-Lite slave that holds per-digit values and scans them onto a shared
// segment bus with programmable dwell and blank gaps between digits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int DIV_W     = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [2:0]  choose,
  output logic [7:0]  bin,
  output logic        frame_tick,
  output logic [1:0]  dbg_state_o
);

  // Bus handshake: a transfer is accepted when HSEL & HTRANS[1] & HREADY in
  // the address phase; the slave never stalls (HREADYOUT=1, HRESP=OKAY), so
  // the data phase always ends at the following edge, where writes commit.
  logic       ap_valid;
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic [3:0] addr_q, addr_d;

  logic [7:0]       digit_q [8];
  logic [7:0]       digit_d [8];
  logic             en_q, en_d;
  logic             dec_q, dec_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [31:0]      rdata;

  logic [1:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       choose_q, choose_d;
  logic [7:0]       bin_q, bin_d;
  logic             tick_q, tick_d;

  logic [DIV_W-1:0] dwell_m1;
  logic [DIV_W-1:0] blank_m1;
  logic             last_idx;
  logic [2:0]       next_idx;
  logic [7:0]       raw_pat;
  logic [7:0]       hex_pat;
  logic [7:0]       pat;
  logic             unused_sink;

  assign ap_valid    = HSEL & HTRANS[1] & HREADY;
  assign unused_sink = ^{HTRANS[0], HSIZE, HPROT, HADDR[31:6], HADDR[1:0], HWDATA};

  always_comb begin
    wr_d   = ap_valid & HWRITE;
    rd_d   = ap_valid & ~HWRITE;
    addr_d = ap_valid ? HADDR[5:2] : addr_q;
  end

  always_comb begin
    digit_d = digit_q;
    en_d    = en_q;
    dec_d   = dec_q;
    div_d   = div_q;
    if (wr_q) begin
      if (addr_q == REG_CTRL) begin
        en_d  = HWDATA[CTRL_EN];
        dec_d = HWDATA[CTRL_DECODE];
      end else if (addr_q == REG_DIV) begin
        div_d = HWDATA[DIV_W-1:0];
      end else if (!addr_q[3] && (int'(addr_q[2:0]) < NDIG)) begin
        digit_d[addr_q[2:0]] = HWDATA[7:0];
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (rd_q) begin
      if (addr_q == REG_CTRL) begin
        rdata[CTRL_EN]     = en_q;
        rdata[CTRL_DECODE] = dec_q;
      end else if (addr_q == REG_DIV) begin
        rdata[DIV_W-1:0] = div_q;
      end else if (!addr_q[3] && (int'(addr_q[2:0]) < NDIG)) begin
        rdata[7:0] = digit_q[addr_q[2:0]];
      end
    end
  end

  // DIV=0 dwells like DIV=1; counters hold "cycles remaining minus one".
  assign dwell_m1 = (div_q == '0) ? '0 : div_q - 1'b1;
  assign blank_m1 = DIV_W'(BLANK_CYC - 1);
  assign last_idx = (idx_q == 3'(NDIG - 1));
  assign next_idx = last_idx ? 3'd0 : idx_q + 3'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (!en_q) begin
      state_d = ST_IDLE;
      idx_d   = 3'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_DRIVE;
          idx_d   = 3'd0;
          cnt_d   = dwell_m1;
        end
        ST_DRIVE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (BLANK_CYC == 0) begin
            idx_d  = next_idx;
            cnt_d  = dwell_m1;
            tick_d = last_idx;
          end else begin
            state_d = ST_BLANK;
            cnt_d   = blank_m1;
          end
        end
        ST_BLANK: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = ST_DRIVE;
            idx_d   = next_idx;
            cnt_d   = dwell_m1;
            tick_d  = last_idx;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  assign raw_pat = digit_q[idx_d];

  seg_hex_decode u_hex (
    .nib_i (raw_pat[3:0]),
    .dp_i  (raw_pat[4]),
    .seg_o (hex_pat)
  );

  assign pat = dec_q ? hex_pat : raw_pat;

  always_comb begin
    choose_d = idx_d;
    bin_d    = (state_d == ST_DRIVE) ? pat : 8'h00;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= 4'd0;
      en_q     <= 1'b0;
      dec_q    <= 1'b0;
      div_q    <= '0;
      state_q  <= ST_IDLE;
      idx_q    <= 3'd0;
      cnt_q    <= '0;
      choose_q <= 3'd0;
      bin_q    <= 8'h00;
      tick_q   <= 1'b0;
      for (int n = 0; n < 8; n++) digit_q[n] <= 8'h00;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      en_q     <= en_d;
      dec_q    <= dec_d;
      div_q    <= div_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      choose_q <= choose_d;
      bin_q    <= bin_d;
      tick_q   <= tick_d;
      for (int n = 0; n < 8; n++) digit_q[n] <= digit_d[n];
    end
  end

  assign HREADYOUT   = 1'b1;
  assign HRESP       = 1'b0;
  assign HRDATA      = rdata;
  assign choose      = choose_q;
  assign bin         = bin_q;
  assign frame_tick  = tick_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: register access, scan timing,
// hex decode, live updates, dwell changes, disable and asynchronous reset.
module tb_seg_scan_ctrl;

  localparam int NDIG      = 4;
  localparam int DIV_W     = 16;
  localparam int BLANK_CYC = 2;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [2:0]  choose;
  logic [7:0]  bin;
  logic        frame_tick;
  logic [1:0]  dbg_state_o;

  seg_scan_ctrl #(.NDIG(NDIG), .DIV_W(DIV_W), .BLANK_CYC(BLANK_CYC)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .choose(choose), .bin(bin),
    .frame_tick(frame_tick), .dbg_state_o(dbg_state_o)
  );

  always #5 HCLK = ~HCLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  pat [4];

  function automatic logic [31:0] disp(input logic [2:0] c, input logic [7:0] b, input logic ft);
    return {20'd0, ft, c, b};
  endfunction

  function automatic logic [31:0] obs();
    return {20'd0, frame_tick, choose, bin};
  endfunction

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'd0;
  endtask

  task automatic addr_phase(input logic [31:0] addr, input logic wr);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr;
    HSIZE = 3'b010; HPROT = 4'b0011;
  endtask

  // Returns #1 after the edge that ends the data phase.
  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge HCLK); #1;
    addr_phase(addr, 1'b1);
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge HCLK); #1;
    addr_phase(addr, 1'b0);
    @(posedge HCLK); #1;
    data = HRDATA;
    bus_idle();
  endtask

  task automatic check_read(input logic [31:0] addr, input logic [31:0] expv);
    logic [31:0] d, e;
    exp_q.push_back(expv);
    ahb_read(addr, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL read_%02h: got %h expected %h", addr[7:0], d, e);
    end
  endtask

  task automatic compare_now(input string name);
    logic [31:0] e;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL %s: got {ft,choose,bin}=%h expected %h", name, obs(), e);
    end
  endtask

  task automatic compare_stream(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge HCLK); #1;
      compare_now(name);
    end
  endtask

  // Expected display sequence starting at the first DRIVE of digit 0.
  task automatic push_scan(input int dwell, input int ncyc);
    int pd, fr, pos, d, w;
    logic [7:0] b;
    pd = dwell + BLANK_CYC;
    fr = NDIG * pd;
    for (int c = 0; c < ncyc; c++) begin
      pos = c % fr;
      d   = pos / pd;
      w   = pos % pd;
      b   = (w < dwell) ? pat[d] : 8'h00;
      exp_q.push_back(disp(3'(d), b, (c > 0) && (pos == 0)));
    end
  endtask

  task automatic wait_drive(input logic [2:0] c, input string name);
    for (int i = 0; i < 200; i++) begin
      @(posedge HCLK); #1;
      if (choose == c && bin != 8'h00) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for digit %0d in drive", name, c);
  endtask

  task automatic check_quiet(input int n, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge HCLK); #1;
      if (frame_tick !== 1'b0 || bin !== 8'h00 || choose !== 3'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d active cycles seen, required 0", name, bad);
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    bus_idle();
    HWDATA = 32'd0; HSIZE = 3'd0; HPROT = 4'd0; HREADY = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    checks++;
    if ({choose, bin, frame_tick, HRDATA, dbg_state_o} !== 46'd0) begin
      errors++;
      $display("FAIL reset_outputs: got choose=%h bin=%h ft=%b hrdata=%h st=%h required all 0",
               choose, bin, frame_tick, HRDATA, dbg_state_o);
    end
    HRESET = 1'b0;
    for (int a = 0; a < 4; a++) check_read(32'(a * 4), 32'd0);
    check_read(32'h20, 32'd0);
    check_read(32'h24, 32'd0);
    check_quiet(30, "reset_idle");
  endtask

  task automatic test_regs();
    pat[0] = 8'h3F; pat[1] = 8'h06; pat[2] = 8'h5B; pat[3] = 8'h4F;
    ahb_write(32'h00, 32'hABCDEF3F);
    for (int a = 1; a < 4; a++) ahb_write(32'(a * 4), {24'hFFFFFF, pat[a]});
    ahb_write(32'h1C, 32'hFF);
    ahb_write(32'h28, 32'hFF);
    ahb_write(32'h24, 32'h12345);
    for (int a = 0; a < 4; a++) check_read(32'(a * 4), {24'd0, pat[a]});
    check_read(32'h1C, 32'd0);
    check_read(32'h28, 32'd0);
    check_read(32'h24, 32'h2345);
    ahb_write(32'h24, 32'd3);
    check_quiet(5, "regs_disabled");
  endtask

  task automatic test_scan();
    ahb_write(32'h20, 32'd1);
    push_scan(3, 45);
    compare_stream(45, "scan_div3");
  endtask

  task automatic test_decode();
    logic [31:0] e;
    ahb_write(32'h08, 32'h1A);
    ahb_write(32'h20, 32'hFFFFFFFF);
    check_read(32'h20, 32'd3);
    exp_q.push_back(32'hF7);
    wait_drive(3'd1, "decode_sync1");
    wait_drive(3'd2, "decode_sync2");
    e = exp_q.pop_front();
    checks++;
    if ({24'd0, bin} !== e) begin
      errors++;
      $display("FAIL decode_dp: got bin=%h expected %h", bin, e[7:0]);
    end
    ahb_write(32'h08, 32'h0A);
    exp_q.push_back(32'h77);
    wait_drive(3'd1, "decode_sync3");
    wait_drive(3'd2, "decode_sync4");
    e = exp_q.pop_front();
    checks++;
    if ({24'd0, bin} !== e) begin
      errors++;
      $display("FAIL decode_a: got bin=%h expected %h", bin, e[7:0]);
    end
    ahb_write(32'h08, {24'd0, pat[2]});
    ahb_write(32'h20, 32'd1);
  endtask

  task automatic test_live_write();
    ahb_write(32'h24, 32'd5);
    wait_drive(3'd0, "live_sync0");
    wait_drive(3'd1, "live_sync1");
    addr_phase(32'h04, 1'b1);
    exp_q.push_back(disp(3'd1, 8'h06, 1'b0));
    exp_q.push_back(disp(3'd1, 8'h06, 1'b0));
    exp_q.push_back(disp(3'd1, 8'h7F, 1'b0));
    exp_q.push_back(disp(3'd1, 8'h7F, 1'b0));
    exp_q.push_back(disp(3'd1, 8'h00, 1'b0));
    @(posedge HCLK); #1;
    compare_now("live_write");
    bus_idle();
    HWDATA = 32'h7F;
    compare_stream(4, "live_write");
    pat[1] = 8'h7F;
  endtask

  task automatic test_div_zero();
    ahb_write(32'h20, 32'd0);
    ahb_write(32'h24, 32'd0);
    ahb_write(32'h20, 32'd1);
    push_scan(1, 26);
    compare_stream(26, "scan_div0");
  endtask

  task automatic test_back_to_back_div();
    ahb_write(32'h20, 32'd0);
    ahb_write(32'h24, 32'd3);
    ahb_write(32'h20, 32'd1);
    addr_phase(32'h24, 1'b1);
    for (int i = 0; i < 3; i++) exp_q.push_back(disp(3'd0, pat[0], 1'b0));
    for (int i = 0; i < 2; i++) exp_q.push_back(disp(3'd0, 8'h00, 1'b0));
    for (int i = 0; i < 8; i++) exp_q.push_back(disp(3'd1, pat[1], 1'b0));
    for (int i = 0; i < 2; i++) exp_q.push_back(disp(3'd1, 8'h00, 1'b0));
    exp_q.push_back(disp(3'd2, pat[2], 1'b0));
    @(posedge HCLK); #1;
    compare_now("div_change");
    bus_idle();
    HWDATA = 32'd8;
    compare_stream(15, "div_change");
  endtask

  task automatic test_disable();
    wait_drive(3'd2, "disable_sync");
    addr_phase(32'h20, 1'b1);
    exp_q.push_back(disp(3'd2, pat[2], 1'b0));
    exp_q.push_back(disp(3'd2, pat[2], 1'b0));
    exp_q.push_back(disp(3'd0, 8'h00, 1'b0));
    exp_q.push_back(disp(3'd0, 8'h00, 1'b0));
    @(posedge HCLK); #1;
    compare_now("disable");
    bus_idle();
    HWDATA = 32'd0;
    compare_stream(3, "disable");
    ahb_write(32'h20, 32'd1);
    push_scan(8, 12);
    compare_stream(12, "reenable");
  endtask

  task automatic test_reset_mid();
    wait_drive(3'd1, "rst_sync");
    #2;
    HRESET = 1'b1;
    #1;
    checks++;
    if ({choose, bin, frame_tick, dbg_state_o} !== 14'd0) begin
      errors++;
      $display("FAIL reset_async: got choose=%h bin=%h ft=%b st=%h required all 0",
               choose, bin, frame_tick, dbg_state_o);
    end
    @(negedge HCLK);
    HRESET = 1'b0;
    check_read(32'h20, 32'd0);
    check_read(32'h04, 32'd0);
    check_read(32'h24, 32'd0);
    check_quiet(25, "reset_mid_idle");
  endtask

  initial begin
    test_reset();
    test_regs();
    test_scan();
    test_decode();
    test_live_write();
    test_div_zero();
    test_back_to_back_div();
    test_disable();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
